// File: rtl/bip_ctrl_pkg.sv
// Shared constants and state encoding for the accumulator-CPU run controller.
// Command bytes arrive from the UART receiver; reports leave through the transmitter.
package bip_ctrl_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;

    localparam int REPORT_BYTES = 6;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_CNT,
        ST_LD_HI,
        ST_LD_LO,
        ST_LD_WR,
        ST_RUN_RST,
        ST_RUN,
        ST_STEP,
        ST_REPORT
    } state_e;

endpackage

// File: rtl/bip_report_tx.sv
// Report serializer: latches a 48-bit snapshot and feeds it MSB byte first
// to the UART transmitter, honouring its ready/start handshake.
module bip_report_tx
    import bip_ctrl_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [8*REPORT_BYTES-1:0] i_snap,
    input  logic                      i_tx_ready,
    output logic [7:0]                o_tx_data,
    output logic                      o_tx_start,
    output logic                      o_done
);

    localparam int IDX_W = $clog2(REPORT_BYTES);

    logic [8*REPORT_BYTES-1:0] snap_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      busy_q;
    logic                      hold_q;
    logic [7:0]                data_q;
    logic [7:0]                cur_byte;
    logic                      last;

    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < REPORT_BYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_byte = snap_q[8*(REPORT_BYTES-1-k) +: 8];
            end
        end
        last       = (idx_q == IDX_W'(REPORT_BYTES - 1));
        // Ready is not trusted on the cycle right after a start pulse.
        o_tx_start = busy_q && !hold_q && i_tx_ready;
        o_tx_data  = o_tx_start ? cur_byte : data_q;
        o_done     = o_tx_start && last;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            snap_q <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            hold_q <= 1'b0;
            data_q <= '0;
        end else begin
            hold_q <= o_tx_start;
            if (i_start) begin
                snap_q <= i_snap;
                idx_q  <= '0;
                busy_q <= 1'b1;
            end else if (o_tx_start) begin
                data_q <= cur_byte;
                if (last) begin
                    busy_q <= 1'b0;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bip_run_ctrl.sv
// Run-control sequencer: loads instruction memory, runs or steps the CPU,
// and reports PC/ACC/cycle count over the UART.
module bip_run_ctrl
    import bip_ctrl_pkg::*;
#(
    parameter int PC_W   = 11,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_tx_ready,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    output logic              o_imem_we,
    output logic [PC_W-1:0]   o_imem_addr,
    output logic [DATA_W-1:0] o_imem_wdata,
    output logic              o_cpu_en,
    output logic              o_cpu_rst,
    input  logic              i_halt,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [DATA_W-1:0] i_acc,
    output logic              o_busy
);

    state_e              state_q, state_d;
    logic [8:0]          left_q, left_d;
    logic [PC_W-1:0]     addr_q, addr_d;
    logic [7:0]          hi_q, hi_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rpt_go_q;
    logic                rpt_done;
    logic [15:0]         pc16, acc16, cnt16;

    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        addr_d    = addr_q;
        hi_d      = hi_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        o_imem_we = 1'b0;
        o_cpu_en  = 1'b0;
        o_cpu_rst = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_d = ST_LD_CNT;
                            addr_d  = '0;
                        end
                        CMD_RUN:  state_d = ST_RUN_RST;
                        CMD_STEP: state_d = ST_STEP;
                        CMD_DUMP: state_d = ST_REPORT;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_LD_CNT: begin
                if (i_rx_valid) begin
                    // A count byte of zero stands for a full 256-word load.
                    left_d  = (i_rx_data == 8'd0) ? 9'd256 : {1'b0, i_rx_data};
                    state_d = ST_LD_HI;
                end
            end
            ST_LD_HI: begin
                if (i_rx_valid) begin
                    hi_d    = i_rx_data;
                    state_d = ST_LD_LO;
                end
            end
            ST_LD_LO: begin
                if (i_rx_valid) begin
                    word_d  = DATA_W'({hi_q, i_rx_data});
                    state_d = ST_LD_WR;
                end
            end
            ST_LD_WR: begin
                o_imem_we = 1'b1;
                addr_d    = addr_q + PC_W'(1);
                left_d    = left_q - 9'd1;
                state_d   = (left_q == 9'd1) ? ST_IDLE : ST_LD_HI;
            end
            ST_RUN_RST: begin
                o_cpu_rst = 1'b1;
                cnt_d     = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (i_halt) begin
                    state_d = ST_REPORT;
                end else begin
                    o_cpu_en = 1'b1;
                end
            end
            ST_STEP: begin
                o_cpu_en = !i_halt;
                state_d  = ST_IDLE;
            end
            ST_REPORT: begin
                if (rpt_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (o_cpu_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            left_q   <= '0;
            addr_q   <= '0;
            hi_q     <= '0;
            word_q   <= '0;
            cnt_q    <= '0;
            rpt_go_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            left_q   <= left_d;
            addr_q   <= addr_d;
            hi_q     <= hi_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            rpt_go_q <= (state_d == ST_REPORT) && (state_q != ST_REPORT);
        end
    end

    always_comb begin
        pc16  = '0;
        acc16 = '0;
        cnt16 = '0;
        pc16[PC_W-1:0]    = i_pc;
        acc16[DATA_W-1:0] = i_acc;
        cnt16[CNT_W-1:0]  = cnt_q;
    end

    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = word_q;
    assign o_busy       = (state_q != ST_IDLE);

    // Snapshot is latched on the first REPORT cycle, after the halt cycle.
    bip_report_tx u_report_tx (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (rpt_go_q),
        .i_snap     ({pc16, acc16, cnt16}),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_done     (rpt_done)
    );

endmodule

// File: tb/tb_bip_run_ctrl.sv
// Bench for bip_run_ctrl: behavioural CPU and UART-TX models around the DUT,
// a vector table, hand sequences for timing corners, and randomized traffic.
module tb_bip_run_ctrl;

    localparam int PC_W   = 11;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              imem_we;
    logic [PC_W-1:0]   imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_en;
    logic              cpu_rst;
    logic              cpu_halt;
    logic [PC_W-1:0]   m_pc;
    logic [DATA_W-1:0] m_acc;
    logic              m_halt;
    logic              busy;

    logic              halt_sel = 1'b0;
    logic              halt_force = 1'b0;
    int                tx_gap = 3;
    int                gap_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int en_cnt = 0;
    int rst_cnt = 0;
    int model_cnt = 0;
    logic prev_start = 1'b0;

    logic [7:0]                tx_q[$];
    logic [PC_W+DATA_W-1:0]    got_q[$];
    logic [PC_W+DATA_W-1:0]    exp_q[$];
    logic [15:0]               ld_q[$];
    logic [DATA_W-1:0]         imem [0:(1<<PC_W)-1];

    always #5 clk = ~clk;

    assign cpu_halt = halt_sel ? halt_force : m_halt;

    bip_run_ctrl #(.PC_W(PC_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_tx_ready   (tx_ready),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_imem_we    (imem_we),
        .o_imem_addr  (imem_addr),
        .o_imem_wdata (imem_wdata),
        .o_cpu_en     (cpu_en),
        .o_cpu_rst    (cpu_rst),
        .i_halt       (cpu_halt),
        .i_pc         (m_pc),
        .i_acc        (m_acc),
        .o_busy       (busy)
    );

    // Tiny CPU: op[15:11] 0=HLT, 3=LDI, 5=ADDI, others NOP; operand [10:0].
    always @(posedge clk) begin
        if (rst || cpu_rst) begin
            m_pc   <= '0;
            m_acc  <= '0;
            m_halt <= 1'b0;
        end else if (cpu_en && !m_halt) begin
            case (imem[m_pc][15:11])
                5'd0: m_halt <= 1'b1;
                5'd3: begin
                    m_acc <= DATA_W'(imem[m_pc][10:0]);
                    m_pc  <= m_pc + 1'b1;
                end
                5'd5: begin
                    m_acc <= m_acc + DATA_W'(imem[m_pc][10:0]);
                    m_pc  <= m_pc + 1'b1;
                end
                default: m_pc <= m_pc + 1'b1;
            endcase
        end
        if (rst) begin
            for (int k = 0; k < (1 << PC_W); k++) imem[k] <= '0;
        end else if (imem_we) begin
            imem[imem_addr] <= imem_wdata;
        end
    end

    // Transmitter: busy for tx_gap cycles after each start pulse.
    always @(posedge clk) begin
        if (rst) begin
            tx_ready <= 1'b1;
            gap_cnt  <= 0;
        end else if (tx_start) begin
            tx_ready <= 1'b0;
            gap_cnt  <= tx_gap;
        end else if (gap_cnt > 1) begin
            gap_cnt <= gap_cnt - 1;
        end else begin
            gap_cnt  <= 0;
            tx_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cpu_en) en_cnt++;
        if (cpu_rst) rst_cnt++;
        if (imem_we) got_q.push_back({imem_addr, imem_wdata});
        if (tx_start) begin
            n_checks++;
            if (!tx_ready || prev_start) begin
                n_fail++;
                $display("FAIL tx_handshake: start with ready=%0b prev_start=%0b, required ready=1 prev_start=0",
                         tx_ready, prev_start);
            end
            tx_q.push_back(tx_data);
        end
        prev_start = tx_start;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk(name, {tx_start, tx_data, imem_we, imem_addr, imem_wdata, cpu_en, cpu_rst, busy}, 64'd0);
    endtask

    task automatic load_words(input int n);
        send_byte(8'h4C);
        send_byte(8'(n));
        for (int k = 0; k < n; k++) begin
            send_byte(ld_q[k][15:8]);
            send_byte(ld_q[k][7:0]);
            exp_q.push_back({PC_W'(k), ld_q[k]});
        end
        wait_cycles(2);
    endtask

    task automatic compare_writes(input string name);
        chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_w%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_report(input string name, input logic [47:0] e);
        int k;
        k = 0;
        while ((busy || tx_q.size() < 6) && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({name, "_nbytes"}, 64'(tx_q.size()), 64'd6);
        chk({name, "_idle"}, 64'(busy), 64'd0);
        for (int i = 0; i < 6 && i < tx_q.size(); i++)
            chk($sformatf("%s_b%0d", name, i), 64'(tx_q[i]), 64'(e[47-8*i -: 8]));
    endtask

    task automatic dump_check(input string name);
        logic [47:0] e;
        e = {5'b0, m_pc, m_acc, 16'(model_cnt)};
        tx_q.delete();
        send_byte(8'h44);
        wait_report(name, e);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic       halt;
        int         en;
        int         rstp;
        int         tx;
    } vec_t;

    vec_t vt [6];
    int   e0, r0, op, n;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0] = '{8'h53, 1'b0, 1, 0, 0};
        vt[1] = '{8'h53, 1'b1, 0, 0, 0};
        vt[2] = '{8'h7F, 1'b0, 0, 0, 0};
        vt[3] = '{8'h44, 1'b0, 0, 0, 6};
        vt[4] = '{8'h41, 1'b1, 0, 0, 0};
        vt[5] = '{8'h00, 1'b0, 0, 0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset_held");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset_released");

        halt_sel = 1'b1;
        foreach (vt[i]) begin
            halt_force = vt[i].halt;
            e0 = en_cnt;
            r0 = rst_cnt;
            tx_q.delete();
            send_byte(vt[i].cmd);
            wait_cycles(60);
            chk($sformatf("vec%0d_en", i), 64'(en_cnt - e0), 64'(vt[i].en));
            chk($sformatf("vec%0d_rst", i), 64'(rst_cnt - r0), 64'(vt[i].rstp));
            chk($sformatf("vec%0d_tx", i), 64'(tx_q.size()), 64'(vt[i].tx));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
            if (vt[i].cmd == 8'h53 && !vt[i].halt) model_cnt++;
        end

        halt_force = 1'b0;
        send_byte(8'h53);
        @(negedge clk);
        chk("step_en_t1", 64'(cpu_en), 64'd1);
        @(negedge clk);
        chk("step_en_t2", 64'(cpu_en), 64'd0);
        model_cnt++;
        halt_sel = 1'b0;
        dump_check("dump_after_steps");

        got_q.delete();
        exp_q.push_back({PC_W'(0), 16'h1805});
        exp_q.push_back({PC_W'(1), 16'h2803});
        send_byte(8'h4C);
        send_byte(8'h02);
        send_byte(8'h18);
        send_byte(8'h05);
        @(negedge clk);
        chk("load_w0_timing", 64'({imem_we, imem_addr, imem_wdata}), 64'({1'b1, 11'd0, 16'h1805}));
        send_byte(8'h28);
        send_byte(8'h03);
        @(negedge clk);
        chk("load_w1_timing", 64'({imem_we, imem_addr, imem_wdata}), 64'({1'b1, 11'd1, 16'h2803}));
        @(negedge clk);
        chk("load_busy_fall", 64'(busy), 64'd0);
        compare_writes("load_plan");

        ld_q = '{16'h1805, 16'h2803, 16'h0000};
        load_words(3);
        compare_writes("load_prog");
        tx_q.delete();
        e0 = en_cnt;
        r0 = rst_cnt;
        send_byte(8'h52);
        @(negedge clk);
        chk("run_rst_t1", 64'({cpu_rst, cpu_en}), 64'({1'b1, 1'b0}));
        @(negedge clk);
        chk("run_en_t2", 64'({cpu_rst, cpu_en}), 64'({1'b0, 1'b1}));
        wait_report("run_report", {16'h0002, 16'h0008, 16'h0003});
        chk("run_rst_pulses", 64'(rst_cnt - r0), 64'd1);
        chk("run_en_cycles", 64'(en_cnt - e0), 64'd3);
        if (tx_q.size() == 6)
            chk("run_cnt_vs_en", 64'({tx_q[4], tx_q[5]}), 64'(en_cnt - e0));
        model_cnt = 3;

        tx_gap = 20;
        dump_check("dump_backpressure");
        tx_gap = 3;

        halt_sel = 1'b1;
        halt_force = 1'b0;
        r0 = rst_cnt;
        send_byte(8'h52);
        wait_cycles(5);
        send_byte(8'h52);
        wait_cycles(5);
        chk("drop_run_rst", 64'(rst_cnt - r0), 64'd1);
        chk("drop_run_state", 64'({busy, cpu_en}), 64'({1'b1, 1'b1}));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset_mid_run");
        halt_sel = 1'b0;
        model_cnt = 0;
        dump_check("dump_after_reset");

        got_q.delete();
        send_byte(8'h4C);
        send_byte(8'h03);
        send_byte(8'h11);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero("reset_mid_load");
        send_byte(8'h22);
        wait_cycles(5);
        chk("reset_load_no_write", 64'(got_q.size()), 64'd0);
        chk("reset_load_idle", 64'(busy), 64'd0);

        ld_q.delete();
        for (int k = 0; k < 256; k++) ld_q.push_back(16'(k * 257) ^ 16'h5A5A);
        load_words(256);
        compare_writes("load_256");

        for (int it = 0; it < 10; it++) begin
            op = $urandom_range(0, 2);
            tx_gap = $urandom_range(1, 6);
            if (op == 0) begin
                n = $urandom_range(1, 5);
                ld_q.delete();
                for (int k = 0; k < n; k++) ld_q.push_back(16'($urandom));
                load_words(n);
                compare_writes($sformatf("rnd%0d_load", it));
            end else if (op == 1) begin
                halt_sel = 1'b1;
                halt_force = 1'($urandom_range(0, 1));
                e0 = en_cnt;
                send_byte(8'h53);
                wait_cycles(3);
                chk($sformatf("rnd%0d_step", it), 64'(en_cnt - e0), 64'(!halt_force));
                if (!halt_force) model_cnt++;
                halt_sel = 1'b0;
            end else begin
                dump_check($sformatf("rnd%0d_dump", it));
            end
        end
        dump_check("dump_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bip_run_ctrl.md
# bip_run_ctrl

Run-control sequencer for the accumulator CPU. It takes command bytes from the UART receiver and uses them to load program words into instruction memory, reset and run the CPU until it halts, or single-step it. After a run it captures a report of PC, ACC and cycle count and serializes it to the UART transmitter. It sits between the UART pair and the CPU top, and is the only block that drives the CPU enable and the instruction-memory write port.

## Interface
- PC_W, 11, instruction address width; must be ≥ 8
- DATA_W, 16, width of the accumulator and instruction word
- CNT_W, 16, width of the executed-cycle counter
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- i_tx_ready  in  1  transmitter idle, can accept a byte
- o_tx_data  out  8  byte to transmit
- o_tx_start  out  1  one-cycle start pulse for transmitter
- o_imem_we  out  1  instruction-memory write enable, one cycle per word
- o_imem_addr  out  PC_W  instruction-memory write address
- o_imem_wdata  out  DATA_W  instruction word to write
- o_cpu_en  out  1  CPU clock enable; PC, ACC and RAM advance only while high
- o_cpu_rst  out  1  CPU reset, one-cycle pulse
- i_halt  in  1  CPU halt flag; stays high until CPU reset
- i_pc  in  PC_W  CPU program counter
- i_acc  in  DATA_W  CPU accumulator
- o_busy  out  1  high in every state except IDLE

## Operation
- **Reset:** on reset the block goes to IDLE with cycle counter = 0. Every output is 0 (o_tx_data, o_imem_addr and o_imem_wdata are 0 as well).
- **Command bytes** are accepted only in IDLE. A byte arriving in any other state, other than load payload, is dropped. Unknown bytes are ignored.
- **'L' (0x4C), load:**
  - The next byte is the word count N; N = 0 means 256.
  - Then 2N bytes follow, each word sent MSB first.
  - Each word is written to address k = 0..N-1 with a single o_imem_we pulse on the cycle after its LSB byte is received.
  - Returns to IDLE after word N-1 is written. No report is sent.
- **'R' (0x52), run:**
  - RUN_RST: o_cpu_rst is high for one cycle and the cycle counter is cleared.
  - RUN: o_cpu_en is held high until i_halt is sampled high. o_cpu_en drops on the cycle i_halt is seen.
  - Then REPORT.
- **'S' (0x53), step:**
  - If i_halt is low, o_cpu_en is high for exactly one cycle, then the block returns to IDLE.
  - If i_halt is high, no enable is issued.
  - No report is sent and no CPU reset is issued.
- **'D' (0x44), dump:** goes to REPORT without touching the CPU.
- **Cycle counter:** increments on every cycle with o_cpu_en = 1 and saturates at 2^CNT_W − 1.
- **REPORT:**
  - On entry, snapshot {zero-extended i_pc to 16 bits, i_acc, counter}.
  - Send 6 bytes in order: PC hi, PC lo, ACC hi, ACC lo, CNT hi, CNT lo. Bytes come from the snapshot only.
  - Return to IDLE after byte 5.
- **States:** IDLE, LD_CNT, LD_HI, LD_LO, LD_WR, RUN_RST, RUN, STEP, REPORT (delegated to the serializer).

## Timing
- **Load latency:** o_imem_we asserts on the cycle after the i_rx_valid that carries the word's LSB byte. Address and data are stable during that cycle.
- **Run start:** the 'R' strobe at cycle t gives o_cpu_rst at t+1 and o_cpu_en from t+2.
- **Halt:** if i_halt is first high at cycle h, o_cpu_en is 0 from h+1 and the snapshot is taken at h+1.
- **Step:** the 'S' strobe at t gives o_cpu_en high only at t+1.
- **TX handshake:**
  - o_tx_start pulses only in a cycle where i_tx_ready = 1, with o_tx_data valid in the same cycle.
  - i_tx_ready is ignored on the cycle after the pulse. The next byte waits until i_tx_ready is seen high again.
  - o_tx_data holds its value until the next pulse.
- **Run with i_halt already high** (e.g. HLT at address 0): after the CPU reset, CPU halt behaviour governs. The controller never stalls, because it always reaches REPORT once i_halt is high.
- **Reset mid-operation:** any partial load is abandoned and o_cpu_en drops next cycle. A partial report is abandoned; no further o_tx_start is issued.
- i_halt and i_rx_valid in the same cycle during RUN: the halt is processed and the byte is dropped.

## Structure
- Package bip_ctrl_pkg holds:
  - command constants CMD_LOAD/CMD_RUN/CMD_STEP/CMD_DUMP
  - the state enum
  - REPORT_BYTES = 6
- Sub-module bip_report_tx:
  - takes the 48-bit snapshot and a start strobe
  - runs the byte counter and TX handshake, and returns a done pulse
- Top FSM, load logic and cycle counter stay in bip_run_ctrl.

## Test plan
- **Load:** bytes 4C, 02, 18, 05, 28, 03 -> o_imem_we pulses at addr 0 with 0x1805 and addr 1 with 0x2803; o_busy falls after the second write.
- **Run:** program LDI 5; ADDI 3; HLT, then 4C…52 -> one o_cpu_rst pulse, o_cpu_en for the run until i_halt, then 6 bytes 00 02 00 08 CNT_hi CNT_lo. Check CNT against cycles counted with o_cpu_en high.
- **Step:** 53 with i_halt = 0 -> exactly one o_cpu_en cycle; 53 with i_halt = 1 -> none; no TX traffic in either case.
- **TX backpressure:** 44 with i_tx_ready held low for 20 cycles between bytes -> 6 pulses, never issued while i_tx_ready = 0, byte order intact.
- **Dropped input:** 0x52 sent during RUN and an unknown 0x7F in IDLE -> both ignored, no state change.
- **Reset mid-run:** i_rst asserted during RUN and during LD_LO -> next cycle all outputs 0, state IDLE, counter 0.
